// File: rtl/store_merge_pkg.sv
// Shared size codes, FSM states and the alignment rule for the store merge path.
package store_merge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // True when a store of this size may start at this byte offset; size 11 never may.
  function automatic logic aligned_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: aligned_ok = 1'b1;
      SZ_HALF: aligned_ok = ~addr_lo[0];
      SZ_WORD: aligned_ok = (addr_lo == 2'b00);
      default: aligned_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational little-endian lane merge: drops the narrow store data into its
// byte lanes and keeps every other lane from the old memory word.
module byte_lane_merge
  import store_merge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] merged_word
);
  localparam int NUM_LANES = DATA_W / 8;

  logic [NUM_LANES-1:0][7:0] old_l, new_l, mrg_l;

  assign old_l       = old_word;
  assign new_l       = new_data;
  assign merged_word = mrg_l;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] K = 2'(k);
    logic [7:0] lane;

    // Pick the source of lane k; a halfword is assumed aligned, so its low
    // byte lands on the even lane of the selected half.
    always_comb begin
      lane = old_l[k];
      case (size)
        SZ_BYTE: if (offset == K) lane = new_l[0];
        SZ_HALF: if (offset[1] == K[1]) lane = K[0] ? new_l[1] : new_l[0];
        SZ_WORD: lane = new_l[k];
        default: lane = old_l[k];
      endcase
    end

    assign mrg_l[k] = lane;
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store narrowing unit: word stores write straight through, byte/halfword
// stores read the target word, merge the new lanes and write it back.
module store_merge_unit
  import store_merge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wack,
  output logic              done,
  output logic              misalign_err
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, wdata_q, merged;
  logic [1:0]        size_q, off_q;
  logic              accept;

  assign accept = req_valid && (state_q == IDLE);

  byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word    (mem_rdata),
    .new_data    (data_q),
    .size        (size_q),
    .offset      (off_q),
    .merged_word (merged)
  );

  // State register; reset abandons any store in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latch the request at acceptance; the write word is seeded with the raw
  // data (word stores) and overwritten with the merged word after the read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
      data_q  <= req_data;
      size_q  <= req_size;
      off_q   <= req_addr[1:0];
      wdata_q <= req_data;
    end else if (state_q == READ && mem_rvalid) begin
      wdata_q <= merged;
    end
  end

  // Next-state and strobes; memory handshakes only count in their own state.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    done         = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!aligned_ok(req_size, req_addr[1:0])) state_d = ERR;
          else if (req_size == SZ_WORD)             state_d = WRITE;
          else                                      state_d = READ;
        end
      end
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        if (mem_rvalid) state_d = WRITE;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_wack) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        misalign_err = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a small wait-state memory responder.
module tb_store_merge_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_rd, mem_rvalid, mem_wr, mem_wack;
  logic        done, misalign_err;

  int errors = 0;
  int checks = 0;

  // responder controls and observations
  int          rd_wait = 0, wr_wait = 0, rd_cnt = 0, wr_cnt = 0;
  int          rd_cycles = 0, wr_cycles = 0;
  logic [31:0] rdata_v = '0, wr_data = '0, wr_addr = '0, rd_addr = '0;
  bit          stray_wack = 0;

  // per-store results
  int ev_cyc, done_n, err_n, busy_ready;
  logic ready_after;

  store_merge_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
    .done(done), .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory model: answers after rd_wait/wr_wait extra cycles of strobe.
  always @(negedge clock) begin
    if (mem_rd) begin rd_cnt++; rd_cycles++; rd_addr = mem_addr; end
    else rd_cnt = 0;
    if (mem_wr) begin wr_cnt++; wr_cycles++; end
    else wr_cnt = 0;
    mem_rvalid = mem_rd && (rd_cnt > rd_wait);
    mem_wack   = (mem_wr && (wr_cnt > wr_wait)) || (mem_rd && stray_wack);
    mem_rdata  = mem_rvalid ? rdata_v : 32'hDEAD0000;
    if (mem_wr && mem_wack) begin wr_data = mem_wdata; wr_addr = mem_addr; end
  end

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int rw, input int ww, input logic [31:0] rdat, input bit stray);
    rd_wait = rw; wr_wait = ww; rdata_v = rdat; stray_wack = stray;
    rd_cycles = 0; wr_cycles = 0; wr_data = '0; wr_addr = '0; rd_addr = '0;
    @(negedge clock);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
    @(posedge clock);  // T0
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_data = 32'h5A5A_5A5A; req_size = 2'b11;
    ev_cyc = 0; done_n = 0; err_n = 0; busy_ready = 0;
    for (int c = 1; c <= 60 && ev_cyc == 0; c++) begin
      @(negedge clock);
      if (req_ready) busy_ready++;
      if (done) begin done_n++; ev_cyc = c; end
      if (misalign_err) begin err_n++; ev_cyc = c; end
    end
    if (ev_cyc == 0) check("timeout", 32'd0, 32'd1);
    @(negedge clock);
    ready_after = req_ready;
    if (done) done_n++;
    if (misalign_err) err_n++;
    stray_wack = 0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_rvalid = 1'b0; mem_wack = 1'b0; mem_rdata = '0;
    #3;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rd",    {31'd0, mem_rd},    32'd0);
    check("rst_wr",    {31'd0, mem_wr},    32'd0);
    check("rst_addr",  mem_addr,           32'd0);
    check("rst_wdata", mem_wdata,          32'd0);
    check("rst_pulse", {30'd0, done, misalign_err}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // byte store into lane 2
    run_store(32'h1002, 32'hAABBCCDD, 2'b00, 0, 0, 32'h11223344, 0);
    check("b_rdaddr", rd_addr, 32'h1000);
    check("b_wraddr", wr_addr, 32'h1000);
    check("b_wdata",  wr_data, 32'h11DD3344);
    check("b_rdcyc",  rd_cycles, 1);
    check("b_wrcyc",  wr_cycles, 1);
    check("b_done",   ev_cyc, 3);
    check("b_pulse",  done_n, 1);
    check("b_busy",   busy_ready, 0);
    check("b_ready",  {31'd0, ready_after}, 32'd1);

    // halfwords low and high
    run_store(32'h2000, 32'h0000BEEF, 2'b01, 0, 0, 32'hFFFFFFFF, 0);
    check("h0_wdata", wr_data, 32'hFFFFBEEF);
    check("h0_done",  ev_cyc, 3);
    run_store(32'h2002, 32'h0000BEEF, 2'b01, 0, 0, 32'hFFFFFFFF, 0);
    check("h2_wdata", wr_data, 32'hBEEFFFFF);
    check("h2_addr",  wr_addr, 32'h2000);

    // word store: no read, done at T0+2
    run_store(32'h3004, 32'hDEADBEEF, 2'b10, 0, 0, 32'h0, 0);
    check("w_rdcyc", rd_cycles, 0);
    check("w_wrcyc", wr_cycles, 1);
    check("w_wdata", wr_data, 32'hDEADBEEF);
    check("w_addr",  wr_addr, 32'h3004);
    check("w_done",  ev_cyc, 2);
    check("w_ready", {31'd0, ready_after}, 32'd1);

    // rejected requests
    run_store(32'h4001, 32'h12345678, 2'b01, 0, 0, 32'h0, 0);
    check("mh_err",  ev_cyc, 1);
    check("mh_pul",  err_n, 1);
    check("mh_mem",  rd_cycles + wr_cycles, 0);
    check("mh_rdy",  {31'd0, ready_after}, 32'd1);
    run_store(32'h4002, 32'h12345678, 2'b10, 0, 0, 32'h0, 0);
    check("mw_err",  ev_cyc, 1);
    check("mw_mem",  rd_cycles + wr_cycles, 0);
    check("mw_done", done_n, 0);
    run_store(32'h4000, 32'h12345678, 2'b11, 0, 0, 32'h0, 0);
    check("ms_err",  ev_cyc, 1);
    check("ms_mem",  rd_cycles + wr_cycles, 0);
    check("ms_rdy",  {31'd0, ready_after}, 32'd1);

    // wait states: rvalid after 3 extra cycles, wack after 2
    run_store(32'h1001, 32'h000000AB, 2'b00, 3, 2, 32'h11223344, 0);
    check("ws_rdcyc", rd_cycles, 4);
    check("ws_wrcyc", wr_cycles, 3);
    check("ws_wdata", wr_data, 32'h1122AB44);
    check("ws_done",  ev_cyc, 8);

    // stray wack while reading must not end the read
    run_store(32'h2002, 32'h00001234, 2'b01, 2, 0, 32'hAABBCCDD, 1);
    check("sw_rdcyc", rd_cycles, 3);
    check("sw_wdata", wr_data, 32'h1234CCDD);
    check("sw_done",  ev_cyc, 5);

    // reset in the middle of a read
    rd_wait = 100; wr_wait = 0; rdata_v = 32'h99999999;
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h6001; req_data = 32'h77; req_size = 2'b00;
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    check("mr_inread", {31'd0, mem_rd}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mr_rd",    {31'd0, mem_rd},    32'd0);
    check("mr_ready", {31'd0, req_ready}, 32'd1);
    check("mr_addr",  mem_addr,           32'd0);
    check("mr_wr",    {31'd0, mem_wr},    32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    rd_cycles = 0; wr_cycles = 0;
    repeat (5) @(negedge clock);
    check("mr_nowr", wr_cycles, 0);
    check("mr_nord", rd_cycles, 0);
    run_store(32'h5008, 32'h0BADF00D, 2'b10, 0, 0, 32'h0, 0);
    check("mr_w_wdata", wr_data, 32'h0BADF00D);
    check("mr_w_wrcyc", wr_cycles, 1);
    check("mr_w_done",  ev_cyc, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
